point_encoder: RTL and testbench

Downstream of the projective-to-affine reduction stage. Takes the affine point (x, y) over GF(2^255−19) and produces the 256-bit Ed25519 compressed encoding: canonical y in bits [254:0], lsb of canonical x in bit 255. It streams the encoding little-endian as WORD_W-bit beats over a valid/ready interface to the output port logic.

---
 rtl/ed25519_pkg.sv | 15 +
 rtl/canon_sub.sv | 16 +
 rtl/point_encoder.sv | 155 +++++++++++++++
 tb/tb_point_encoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ed25519_pkg.sv
// Shared Ed25519 constants and point-encoder state type.
package ed25519_pkg;

  localparam logic [254:0] P_25519 =
    255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;

  localparam int ENC_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    CANON,
    STREAM
  } point_enc_state_t;

endpackage

// File: rtl/canon_sub.sv
// Reduces a value below 2^255 to canonical form mod P_25519 with one conditional subtract.
module canon_sub
  import ed25519_pkg::*;
(
  input  logic [254:0] value,
  output logic [254:0] canon
);

  always_comb begin
    canon = value;
    if (value >= P_25519) begin
      canon = value - P_25519;
    end
  end

endmodule

// File: rtl/point_encoder.sv
// Ed25519 point compression: streams {lsb(x), y} little-endian as WORD_W-bit beats.
// Canonicalisation of x/y (CANON state + subtractors) is enabled by POINT_ENC_CANON_EN.
module point_encoder
  import ed25519_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [254:0]      i_x,
  input  logic [254:0]      i_y,
  output logic              o_ready,
  output logic              o_drop,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_data,
  output logic              o_last
);

  localparam int NBEATS = ENC_W / WORD_W;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(NBEATS - 2);

  point_enc_state_t state, state_next;

  logic [ENC_W-1:0] enc, enc_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ready_r, drop_r, valid_r, last_r;
  logic             ready_next, drop_next, valid_next, last_next;
  logic             capture, beat_fire;

  assign capture   = (state == IDLE) && i_valid && ready_r;
  assign beat_fire = (state == STREAM) && valid_r && i_ready;

`ifdef POINT_ENC_CANON_EN
  logic [254:0] x_q, y_q, x_c, y_c;
  logic [253:0] x_c_unused;

  canon_sub u_canon_x (
    .value (x_q),
    .canon (x_c)
  );

  canon_sub u_canon_y (
    .value (y_q),
    .canon (y_c)
  );

  // Only the parity of canonical x reaches the encoding.
  assign x_c_unused = x_c[254:1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (capture) begin
      x_q <= i_x;
      y_q <= i_y;
    end
  end
`else
  logic [253:0] x_unused;

  assign x_unused = i_x[254:1];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (capture) begin
`ifdef POINT_ENC_CANON_EN
          state_next = CANON;
`else
          state_next = STREAM;
`endif
        end
      end
      CANON:   state_next = STREAM;
      STREAM:  if (beat_fire && last_r) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // enc is a shift register: the current beat always sits in the low WORD_W
  // bits, so o_data comes straight from flops and drains to zero after the last beat.
  always_comb begin
    enc_next  = enc;
    cnt_next  = cnt;
    last_next = last_r;
    unique case (state)
      IDLE: begin
`ifndef POINT_ENC_CANON_EN
        if (capture) begin
          enc_next  = {i_x[0], i_y};
          cnt_next  = '0;
          last_next = 1'b0;
        end
`endif
      end
      CANON: begin
`ifdef POINT_ENC_CANON_EN
        enc_next = {x_c[0], y_c};
`endif
        cnt_next  = '0;
        last_next = 1'b0;
      end
      STREAM: begin
        if (beat_fire) begin
          enc_next  = enc >> WORD_W;
          cnt_next  = cnt + 1'b1;
          last_next = !last_r && (cnt == CNT_PRE_LAST);
        end
      end
      default: ;
    endcase
    ready_next = (state_next == IDLE);
    valid_next = (state_next == STREAM);
    drop_next  = i_valid && (state != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      enc     <= '0;
      cnt     <= '0;
      ready_r <= 1'b0;
      drop_r  <= 1'b0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      enc     <= enc_next;
      cnt     <= cnt_next;
      ready_r <= ready_next;
      drop_r  <= drop_next;
      valid_r <= valid_next;
      last_r  <= last_next;
    end
  end

  assign o_ready = ready_r;
  assign o_drop  = drop_r;
  assign o_valid = valid_r;
  assign o_last  = last_r;
  assign o_data  = enc[WORD_W-1:0];

endmodule

// File: tb/tb_point_encoder.sv
// Directed, table-driven bench for point_encoder (WORD_W=64); expectations follow POINT_ENC_CANON_EN.
module tb_point_encoder;

  localparam int W  = 64;
  localparam int NB = 256 / W;

  localparam logic [254:0] P =
    255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
  localparam logic [254:0] X1 =
    255'd32550001060033536116573324601327423096500964215453530490263698861761376554278;
  localparam logic [254:0] Y1 =
    255'd31803597324864083720364488970779197587133653988662377891460026891000616404072;
  localparam logic [254:0] ONES = '1;
  localparam logic [254:0] ZERO = '0;

  typedef struct {
    string        name;
    logic [254:0] x;
    logic [254:0] y;
    logic [255:0] enc;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [254:0]  in_x;
  logic [254:0]  in_y;
  logic          out_ready;
  logic          out_drop;
  logic          out_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_last;

  int checks;
  int errors;

  point_encoder #(.WORD_W(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .i_x     (in_x),
    .i_y     (in_y),
    .o_ready (out_ready),
    .o_drop  (out_drop),
    .o_valid (out_valid),
    .i_ready (in_ready),
    .o_data  (out_data),
    .o_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (out_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk({name, " ready_before_send"}, 256'(out_ready), 256'd1);
  endtask

  task automatic send_point(input logic [254:0] x, input logic [254:0] y, input string name);
    wait_ready(name);
    in_x     = x;
    in_y     = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({name, " ready_fall"}, 256'(out_ready), 256'd0);
`ifdef POINT_ENC_CANON_EN
    chk({name, " canon_gap_valid"}, 256'(out_valid), 256'd0);
    step();
`endif
  endtask

  task automatic recv(input logic [255:0] exp, input int stall_beat, input int stall_n,
                      input int drop_beat, input string name);
    logic [W-1:0] beat;
    for (int b = 0; b < NB; b++) begin
      beat = exp[b*W +: W];
      chk($sformatf("%s b%0d valid", name, b), 256'(out_valid), 256'd1);
      chk($sformatf("%s b%0d data", name, b), 256'(out_data), 256'(beat));
      chk($sformatf("%s b%0d last", name, b), 256'(out_last), 256'(b == NB - 1));
      chk($sformatf("%s b%0d drop", name, b), 256'(out_drop), 256'(b == drop_beat + 1));
      if (b == stall_beat) begin
        in_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          step();
          chk($sformatf("%s stall%0d valid", name, s), 256'(out_valid), 256'd1);
          chk($sformatf("%s stall%0d data", name, s), 256'(out_data), 256'(beat));
          chk($sformatf("%s stall%0d last", name, s), 256'(out_last), 256'(b == NB - 1));
        end
        in_ready = 1'b1;
      end
      if (b == drop_beat) begin
        in_x     = ONES;
        in_y     = ONES;
        in_valid = 1'b1;
      end
      step();
      in_valid = 1'b0;
    end
    chk({name, " end valid"}, 256'(out_valid), 256'd0);
    chk({name, " end ready"}, 256'(out_ready), 256'd1);
    chk({name, " end last"}, 256'(out_last), 256'd0);
    chk({name, " end drop"}, 256'(out_drop), 256'(drop_beat == NB - 1));
    if (drop_beat == NB - 1) begin
      step();
      chk({name, " post drop clear"}, 256'(out_drop), 256'd0);
      chk({name, " post drop no capture"}, 256'(out_valid), 256'd0);
      chk({name, " post drop ready"}, 256'(out_ready), 256'd1);
    end
  endtask

  initial begin
    vec_t vecs[5];
    logic [255:0] enc1;

    enc1    = {1'b0, Y1};
    vecs[0] = '{"plan1", X1, Y1, enc1};
    vecs[3] = '{"below_p", P - 255'd1, P - 255'd1, {1'b0, P - 255'd1}};
`ifdef POINT_ENC_CANON_EN
    vecs[1] = '{"y_eq_p", 255'd1, P, {1'b1, ZERO}};
    vecs[2] = '{"y_max", P + 255'd1, ONES, {1'b1, 255'd18}};
    vecs[4] = '{"x_eq_p", P, ZERO, {1'b0, ZERO}};
`else
    vecs[1] = '{"y_eq_p", 255'd1, P, {1'b1, P}};
    vecs[2] = '{"y_max", P + 255'd1, ONES, {1'b0, ONES}};
    vecs[4] = '{"x_eq_p", P, ZERO, {1'b1, ZERO}};
`endif

    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_ready = 1'b0;
    in_x     = '0;
    in_y     = '0;

    #12;
    chk("reset ready", 256'(out_ready), 256'd0);
    chk("reset valid", 256'(out_valid), 256'd0);
    chk("reset data", 256'(out_data), 256'd0);
    chk("reset last", 256'(out_last), 256'd0);
    chk("reset drop", 256'(out_drop), 256'd0);
    step();
    rst_n = 1'b1;
    chk("release ready low", 256'(out_ready), 256'd0);
    step();
    chk("release ready rise", 256'(out_ready), 256'd1);

    in_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_point(vecs[i].x, vecs[i].y, vecs[i].name);
      recv(vecs[i].enc, -1, 0, -10, vecs[i].name);
    end

    send_point(X1, Y1, "stall");
    recv(enc1, 1, 3, -10, "stall");

    send_point(X1, Y1, "drop_mid");
    recv(enc1, -1, 0, 2, "drop_mid");

    send_point(X1, Y1, "drop_last");
    recv(enc1, -1, 0, NB - 1, "drop_last");

    send_point(X1, Y1, "rst_mid");
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("rst_mid b%0d data", b), 256'(out_data), 256'(enc1[b*W +: W]));
      step();
    end
    chk("rst_mid b2 presented", 256'(out_data), 256'(enc1[2*W +: W]));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid valid", 256'(out_valid), 256'd0);
    chk("rst_mid data", 256'(out_data), 256'd0);
    chk("rst_mid ready", 256'(out_ready), 256'd0);
    chk("rst_mid last", 256'(out_last), 256'd0);
    step();
    rst_n = 1'b1;
    chk("rst_mid ready held low", 256'(out_ready), 256'd0);
    step();
    chk("rst_mid ready rise", 256'(out_ready), 256'd1);
    chk("rst_mid no resume", 256'(out_valid), 256'd0);
    send_point(vecs[2].x, vecs[2].y, "after_rst");
    recv(vecs[2].enc, -1, 0, -10, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
